// File: rtl/heap_sort_ctrl.sv
// heap_sort_ctrl: front-end sequencer for the pipelined heap-sort datapath.
// It runs the memory-clear sweep, takes a valid/ready element stream and
// spaces root insertions by ISSUE_GAP cycles. It then waits for the last
// element to ripple through every level and pulses done.
// Every output comes straight from a register, so there is no
// combinational path from s_valid to s_ready.
module heap_sort_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 1,
    parameter int LEVELS      = 4,
    parameter int ISSUE_GAP   = 2,
    parameter int INIT_CYCLES = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  init_out,
    output logic                  pl_update_out,
    output logic [DATA_WIDTH-1:0] pl_out,
    output logic [ADDR_WIDTH-1:0] pl_addr_out,
    output logic                  pl_branch_out,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  elem_count
);

    // Drain time: the final element needs ISSUE_GAP cycles per level.
    localparam int DRAIN_CYCLES = LEVELS * ISSUE_GAP;

    // One shared cycle counter serves both INIT and DRAIN. It counts
    // 0 .. N-1, so it must be wide enough for the longer of the two phases.
    localparam int CYC_MAX = (INIT_CYCLES > DRAIN_CYCLES) ? INIT_CYCLES : DRAIN_CYCLES;
    localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
    localparam int GAP_W   = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

    localparam logic [CYC_W-1:0] INIT_LAST  = CYC_W'(INIT_CYCLES - 1);
    localparam logic [CYC_W-1:0] DRAIN_LAST = CYC_W'(DRAIN_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(ISSUE_GAP - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t                  state_reg,   state_next;
    logic [CYC_W-1:0]        cyc_reg,     cyc_next;
    logic [GAP_W-1:0]        gap_reg,     gap_next;
    logic                    s_ready_reg, s_ready_next;
    logic                    init_reg,    init_next;
    logic                    upd_reg,     upd_next;
    logic [DATA_WIDTH-1:0]   pl_reg,      pl_next;
    logic                    done_reg,    done_next;
    logic                    busy_reg,    busy_next;
    logic [CNT_WIDTH-1:0]    count_reg,   count_next;
    logic                    accept;

    // An element is taken only in RUN, while the registered ready is high.
    assign accept = (state_reg == ST_RUN) && s_valid && s_ready_reg;

    // Next-state and next-output logic. Strobes default low and data holds.
    always_comb begin
        state_next   = state_reg;
        cyc_next     = cyc_reg;
        gap_next     = gap_reg;
        s_ready_next = 1'b0;
        init_next    = 1'b0;
        upd_next     = 1'b0;
        pl_next      = pl_reg;
        done_next    = 1'b0;
        count_next   = count_reg;

        case (state_reg)
            ST_IDLE: begin
                // abort beats start when both arrive in IDLE.
                if (start && !abort) begin
                    state_next = ST_INIT;
                    cyc_next   = '0;
                    gap_next   = '0;
                    count_next = '0;
                    init_next  = 1'b1;
                end
            end

            ST_INIT: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    cyc_next   = '0;
                end else if (cyc_reg == INIT_LAST) begin
                    state_next   = ST_RUN;
                    cyc_next     = '0;
                    gap_next     = '0;
                    s_ready_next = 1'b1;
                end else begin
                    cyc_next = cyc_reg + CYC_W'(1);
                end
            end

            ST_RUN: begin
                if (abort) begin
                    // An accept in this same cycle is dropped.
                    state_next = ST_IDLE;
                    gap_next   = '0;
                end else if (accept) begin
                    upd_next = 1'b1;
                    pl_next  = s_data;
                    if (count_reg != CNT_MAX) begin
                        count_next = count_reg + CNT_WIDTH'(1);
                    end
                    if (s_last) begin
                        state_next = ST_DRAIN;
                        cyc_next   = '0;
                        gap_next   = '0;
                    end else begin
                        gap_next     = GAP_RELOAD;
                        s_ready_next = (GAP_RELOAD == '0);
                    end
                end else begin
                    // The gap keeps counting down whether or not s_valid is high.
                    if (gap_reg != '0) begin
                        gap_next = gap_reg - GAP_W'(1);
                    end
                    s_ready_next = (gap_reg <= GAP_W'(1));
                end
            end

            ST_DRAIN: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    cyc_next   = '0;
                end else if (cyc_reg == DRAIN_LAST) begin
                    state_next = ST_IDLE;
                    cyc_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    cyc_next = cyc_reg + CYC_W'(1);
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    // State and output registers. rst takes priority over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cyc_reg     <= '0;
            gap_reg     <= '0;
            s_ready_reg <= 1'b0;
            init_reg    <= 1'b0;
            upd_reg     <= 1'b0;
            pl_reg      <= '0;
            done_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            count_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            cyc_reg     <= cyc_next;
            gap_reg     <= gap_next;
            s_ready_reg <= s_ready_next;
            init_reg    <= init_next;
            upd_reg     <= upd_next;
            pl_reg      <= pl_next;
            done_reg    <= done_next;
            busy_reg    <= busy_next;
            count_reg   <= count_next;
        end
    end

    assign s_ready       = s_ready_reg;
    assign init_out      = init_reg;
    assign pl_update_out = upd_reg;
    assign pl_out        = pl_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign elem_count    = count_reg;

    // The root node always lives at address 0 and is reached along branch 0.
    assign pl_addr_out   = '0;
    assign pl_branch_out = 1'b0;

endmodule

// File: tb/tb_heap_sort_ctrl.sv
// Directed bench for heap_sort_ctrl.
// Instance a uses the default parameters (ISSUE_GAP=2).
// Instance b uses ISSUE_GAP=1 for back-to-back insertion.
// Inputs are driven and outputs are sampled on the falling edge.
module tb_heap_sort_ctrl;

    logic        clk;
    logic        rst;

    logic        start_a, abort_a, s_valid_a, s_last_a;
    logic [31:0] s_data_a;
    logic        s_ready_a, init_a, upd_a, branch_a, busy_a, done_a;
    logic [31:0] pl_a;
    logic [0:0]  addr_a;
    logic [15:0] count_a;

    logic        start_b, abort_b, s_valid_b, s_last_b;
    logic [31:0] s_data_b;
    logic        s_ready_b, init_b, upd_b, branch_b, busy_b, done_b;
    logic [31:0] pl_b;
    logic [0:0]  addr_b;
    logic [15:0] count_b;

    int total;
    int bad;
    int tally;

    heap_sort_ctrl dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .s_valid(s_valid_a), .s_ready(s_ready_a), .s_data(s_data_a), .s_last(s_last_a),
        .init_out(init_a), .pl_update_out(upd_a), .pl_out(pl_a),
        .pl_addr_out(addr_a), .pl_branch_out(branch_a),
        .busy(busy_a), .done(done_a), .elem_count(count_a)
    );

    heap_sort_ctrl #(.ISSUE_GAP(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data_b), .s_last(s_last_b),
        .init_out(init_b), .pl_update_out(upd_b), .pl_out(pl_b),
        .pl_addr_out(addr_b), .pl_branch_out(branch_b),
        .busy(busy_b), .done(done_b), .elem_count(count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start on instance a, then walk through INIT until ready comes up.
    task automatic run_init_a(input string tag);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        check({tag, "_count_clr"}, 32'(count_a), 32'd0);
        repeat (15) step();
        check({tag, "_ready_late"}, 32'(s_ready_a), 32'd0);
        step();
        check({tag, "_ready_on"}, 32'(s_ready_a), 32'd1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        start_a = 1'b0; abort_a = 1'b0; s_valid_a = 1'b0; s_last_a = 1'b0; s_data_a = '0;
        start_b = 1'b0; abort_b = 1'b0; s_valid_b = 1'b0; s_last_b = 1'b0; s_data_b = '0;
        repeat (3) step();

        // Reset state
        check("rst_ready", 32'(s_ready_a), 32'd0);
        check("rst_init",  32'(init_a),    32'd0);
        check("rst_upd",   32'(upd_a),     32'd0);
        check("rst_done",  32'(done_a),    32'd0);
        check("rst_busy",  32'(busy_a),    32'd0);
        check("rst_pl",    pl_a,           32'd0);
        check("rst_count", 32'(count_a),   32'd0);
        rst = 1'b0;
        step();

        // start -> INIT: init_out for one cycle, ready 16 cycles after start edge
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        check("init_busy", 32'(busy_a), 32'd1);
        check("init_pulse", 32'(init_a), 32'd1);
        check("init_ready0", 32'(s_ready_a), 32'd0);
        tally = 0;
        for (int i = 1; i <= 15; i++) begin
            step();
            if (init_a || s_ready_a) tally++;
        end
        check("init_quiet", 32'(tally), 32'd0);
        step();
        check("run_ready", 32'(s_ready_a), 32'd1);
        check("run_init_low", 32'(init_a), 32'd0);

        // Three elements with s_valid held, ISSUE_GAP=2
        s_valid_a = 1'b1; s_data_a = 32'h1000;
        step();
        check("e1_upd",   32'(upd_a),     32'd1);
        check("e1_pl",    pl_a,           32'h1000);
        check("e1_count", 32'(count_a),   32'd1);
        check("e1_ready", 32'(s_ready_a), 32'd0);
        s_data_a = 32'h2000;
        step();
        check("gap1_upd",   32'(upd_a),     32'd0);
        check("gap1_ready", 32'(s_ready_a), 32'd1);
        step();
        check("e2_upd",   32'(upd_a),   32'd1);
        check("e2_pl",    pl_a,         32'h2000);
        check("e2_count", 32'(count_a), 32'd2);
        s_data_a = 32'h3000; s_last_a = 1'b1;
        step();
        check("gap2_upd", 32'(upd_a), 32'd0);
        check("gap2_pl",  pl_a,       32'h2000);
        step();
        check("e3_upd",   32'(upd_a),   32'd1);
        check("e3_pl",    pl_a,         32'h3000);
        check("e3_count", 32'(count_a), 32'd3);
        s_valid_a = 1'b0; s_last_a = 1'b0;
        tally = 0;
        for (int i = 1; i <= 7; i++) begin
            step();
            if (done_a || !busy_a || s_ready_a || upd_a) tally++;
        end
        check("drain_quiet", 32'(tally), 32'd0);
        step();
        check("drain_done", 32'(done_a), 32'd1);
        check("drain_busy", 32'(busy_a), 32'd0);
        step();
        check("done_once", 32'(done_a), 32'd0);
        check("cnt_kept",  32'(count_a), 32'd3);

        // start and abort together in IDLE: abort wins
        start_a = 1'b1; abort_a = 1'b1;
        step();
        start_a = 1'b0; abort_a = 1'b0;
        check("sa_busy", 32'(busy_a), 32'd0);
        check("sa_init", 32'(init_a), 32'd0);

        // start pulsed during RUN is ignored
        run_init_a("r2");
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        check("rs_busy",  32'(busy_a),    32'd1);
        check("rs_ready", 32'(s_ready_a), 32'd1);
        check("rs_init",  32'(init_a),    32'd0);
        check("rs_count", 32'(count_a),   32'd0);

        // abort on the accept cycle of the second element
        s_valid_a = 1'b1; s_data_a = 32'h00A1;
        step();
        check("ab_e1_upd", 32'(upd_a), 32'd1);
        s_data_a = 32'h00A2;
        step();
        check("ab_ready", 32'(s_ready_a), 32'd1);
        abort_a = 1'b1;
        step();
        abort_a = 1'b0; s_valid_a = 1'b0;
        check("ab_upd",   32'(upd_a),     32'd0);
        check("ab_busy",  32'(busy_a),    32'd0);
        check("ab_ready0", 32'(s_ready_a), 32'd0);
        check("ab_done",  32'(done_a),    32'd0);
        check("ab_count", 32'(count_a),   32'd1);
        check("ab_pl",    pl_a,           32'h00A1);
        tally = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (done_a || busy_a || upd_a) tally++;
        end
        check("ab_quiet", 32'(tally), 32'd0);

        // single element with s_last on the first accept
        run_init_a("r3");
        s_valid_a = 1'b1; s_last_a = 1'b1; s_data_a = 32'h0055;
        step();
        s_valid_a = 1'b0; s_last_a = 1'b0;
        check("one_upd",   32'(upd_a),     32'd1);
        check("one_pl",    pl_a,           32'h0055);
        check("one_count", 32'(count_a),   32'd1);
        check("one_ready", 32'(s_ready_a), 32'd0);
        tally = 0;
        for (int i = 1; i <= 7; i++) begin
            step();
            if (done_a || upd_a) tally++;
        end
        check("one_quiet", 32'(tally), 32'd0);
        step();
        check("one_done", 32'(done_a), 32'd1);
        check("one_busy", 32'(busy_a), 32'd0);

        // Instance b, ISSUE_GAP=1: five back-to-back elements
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        check("b_init", 32'(init_b), 32'd1);
        repeat (15) step();
        check("b_ready_late", 32'(s_ready_b), 32'd0);
        step();
        check("b_ready", 32'(s_ready_b), 32'd1);
        s_valid_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data_b = 32'h00B0 + 32'(i);
            s_last_b = (i == 4);
            step();
            check("b_upd",   32'(upd_b),   32'd1);
            check("b_pl",    pl_b,         32'h00B0 + 32'(i));
            check("b_count", 32'(count_b), 32'(i + 1));
        end
        s_valid_b = 1'b0; s_last_b = 1'b0;
        check("b_ready_off", 32'(s_ready_b), 32'd0);
        tally = 0;
        for (int i = 1; i <= 3; i++) begin
            step();
            if (done_b || upd_b || !busy_b) tally++;
        end
        check("b_drain_quiet", 32'(tally), 32'd0);
        step();
        check("b_done", 32'(done_b), 32'd1);
        check("b_busy", 32'(busy_b), 32'd0);
        check("b_addr",   32'(addr_b),   32'd0);
        check("b_branch", 32'(branch_b), 32'd0);
        check("a_addr",   32'(addr_a),   32'd0);
        check("a_branch", 32'(branch_a), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
